// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC tile sequencer slice.
package mac_pkg;

  localparam int NCOL  = 8;
  localparam int RES_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    OUT
  } seq_state_e;

  typedef logic [NCOL-1:0][RES_W-1:0] res_vec_t;

endpackage

// File: rtl/mac_col_accum.sv
// Per-column accumulators for the engine results; MAC_SEQ_SAT_EN selects
// saturating instead of wrapping accumulation.
module mac_col_accum
  import mac_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [NCOL*RES_W-1:0]   res_i,
  output logic [NCOL*ACC_W-1:0]   acc_o
);

  res_vec_t                      res;
  logic [NCOL-1:0][ACC_W-1:0]    acc_q;
  logic [NCOL-1:0][ACC_W-1:0]    acc_d;
  logic [NCOL-1:0][ACC_W:0]      sum;

  assign res   = res_i;
  assign acc_o = acc_q;

  // One extra bit of headroom exposes the carry for the saturating build.
  always_comb begin
    sum   = '0;
    acc_d = '0;
    for (int unsigned k = 0; k < NCOL; k++) begin
      sum[k] = {1'b0, acc_q[k]} + (ACC_W + 1)'(res[k]);
`ifdef MAC_SEQ_SAT_EN
      acc_d[k] = sum[k][ACC_W] ? '1 : sum[k][ACC_W-1:0];
`else
      acc_d[k] = sum[k][ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mac_tile_sequencer.sv
// Sequences one output tile through mac_engine and returns the column sums
// over valid/ready. Optional macro: MAC_SEQ_SAT_EN (saturating accumulators).
module mac_tile_sequencer
  import mac_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = 12,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        num_chunks_i,
  input  logic [ADDR_W-1:0]       act_base_i,
  input  logic [ADDR_W-1:0]       w_base_i,
  output logic                    rd_en_o,
  output logic [ADDR_W-1:0]       act_addr_o,
  output logic [ADDR_W-1:0]       w_addr_o,
  input  logic [NCOL*RES_W-1:0]   mac_res_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [NCOL*ACC_W-1:0]   out_data_o,
  output logic                    busy_o,
  output logic                    done_o
);

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   act_q, w_q;
  logic [RD_LAT:0]     vld_q;
  logic                zdone_q;
  logic                accept, zero_start, handshake;

  assign zero_start = (state_q == IDLE) && start_i && (num_chunks_i == '0);
  assign accept     = (state_q == IDLE) && start_i && (num_chunks_i != '0);
  assign act_addr_o = act_q;
  assign w_addr_o   = w_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = zdone_q | handshake;

  always_comb begin
    state_d     = state_q;
    rd_en_o     = 1'b0;
    out_valid_o = 1'b0;
    handshake   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = FETCH;
      end
      FETCH: begin
        rd_en_o = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (vld_q == '0) state_d = OUT;
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      w_q     <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zdone_q <= zero_start;
      if (accept) begin
        cnt_q <= num_chunks_i;
        act_q <= act_base_i;
        w_q   <= w_base_i;
      end else if (state_q == FETCH) begin
        cnt_q <= cnt_q - CNT_W'(1);
        act_q <= act_q + ADDR_W'(1);
        w_q   <= w_q + ADDR_W'(1);
      end
    end
  end

  // Tail of this shift register marks the cycle the engine result belongs to a read.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_en_o;
      for (int unsigned i = 1; i <= RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  mac_col_accum #(
    .ACC_W (ACC_W)
  ) u_accum (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (accept),
    .en    (vld_q[RD_LAT]),
    .res_i (mac_res_i),
    .acc_o (out_data_o)
  );

endmodule
